// File: rtl/fetch_prefetch_if.sv
// Fetch/decode bus for fetch_prefetch: memory read port, redirect inputs and
// the decode-side valid/ready head of the prefetch queue.
interface fetch_prefetch_if #(
    parameter int unsigned N     = 24,
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [N-1:0]  instruction;
    logic [N-1:0]  ResultW;
    logic          PCSrcW;
    logic [N-1:0]  BranchTargetE;
    logic          BranchTakenE;
    logic          ReadyD;

    logic [N-1:0]  PCF;
    logic          ValidD;
    logic          VectorD;
    logic [N-1:0]  InstrD;
    logic [N-1:0]  InstrD_vector;
    logic [N-1:0]  PCPlus8D;
    logic [CW-1:0] CountF;

    modport master (
        input  instruction, ResultW, PCSrcW, BranchTargetE, BranchTakenE, ReadyD,
        output PCF, ValidD, VectorD, InstrD, InstrD_vector, PCPlus8D, CountF
    );

    modport slave (
        output instruction, ResultW, PCSrcW, BranchTargetE, BranchTakenE, ReadyD,
        input  PCF, ValidD, VectorD, InstrD, InstrD_vector, PCPlus8D, CountF
    );
endinterface

// File: rtl/fetch_prefetch.sv
// Fetch stage with a DEPTH-entry prefetch queue; fetch runs ahead of decode
// and any Execute/Writeback redirect flushes the queue.
module fetch_prefetch #(
    parameter int unsigned   N        = 24,
    parameter int unsigned   DEPTH    = 4,
    parameter logic [N-1:0]  RESET_PC = '0,
    parameter int unsigned   PC_STEP  = 4,
    parameter int unsigned   VBIT     = 20
) (
    input  logic             clk,
    input  logic             rst,
    fetch_prefetch_if.master bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [N-1:0]  pcReg;
    logic [N-1:0]  pcMem    [DEPTH];
    logic [N-1:0]  instrMem [DEPTH];
    logic [AW-1:0] rdPtr;
    logic [AW-1:0] wrPtr;
    logic [CW-1:0] count;

    logic          redir;
    logic [N-1:0]  target;
    logic          validHead;
    logic          pop;
    logic          push;
    logic [N-1:0]  headPc;
    logic [N-1:0]  headInstr;

    always_comb begin
        redir     = bus.PCSrcW | bus.BranchTakenE;
        target    = bus.PCSrcW ? bus.ResultW : bus.BranchTargetE;
        validHead = (count != '0) & ~redir;
        pop       = validHead & bus.ReadyD;
        // A pop in the same cycle frees the slot, so a full queue keeps streaming.
        push      = ~redir & ((count != FULL_COUNT) | pop);
        headPc    = pcMem[rdPtr];
        headInstr = instrMem[rdPtr];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pcReg <= RESET_PC;
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else if (redir) begin
            pcReg <= target;
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else begin
            if (push) begin
                pcReg <= pcReg + N'(PC_STEP);
                wrPtr <= wrPtr + 1'b1;
            end
            if (pop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only observed behind validHead.
    always_ff @(posedge clk) begin
        if (push) begin
            pcMem[wrPtr]    <= pcReg;
            instrMem[wrPtr] <= bus.instruction;
        end
    end

    always_comb begin
        bus.PCF           = pcReg;
        bus.CountF        = count;
        bus.ValidD        = validHead;
        bus.VectorD       = validHead & headInstr[VBIT];
        bus.InstrD        = (validHead & ~headInstr[VBIT]) ? headInstr : '0;
        bus.InstrD_vector = (validHead &  headInstr[VBIT]) ? headInstr : '0;
        bus.PCPlus8D      = validHead ? (headPc + N'(8)) : '0;
    end
endmodule

// File: doc/fetch_prefetch.md
# fetch_prefetch

Parametrised fetch stage with an instruction prefetch queue, for the pipelined vector/scalar processor. Drives `PCF` to instruction memory, captures each returned word with its PC into a DEPTH-entry FIFO, and presents the oldest entry to decode through a valid/ready handshake. Each entry is routed to a scalar or vector lane by its V bit. Fetch decouples from decode back-pressure, and redirects from Execute (branch) or Writeback (PC write) flush the queue.

## Interface
- `N`, 24: instruction and PC width.
- `DEPTH`, 4: prefetch queue entries; a power of two, at least 2.
- `RESET_PC`, 0: PC value loaded on reset.
- `PC_STEP`, 4: sequential PC increment.
- `VBIT`, 20: bit index of the vector flag in the instruction.
- `clk` input 1: the single clock; all state updates on the rising edge.
- `rst` input 1: reset; asynchronous, active-low (0 = reset).
- `instruction` input N: combinational memory read data for `PCF`.
- `ResultW` input N: redirect target from Writeback.
- `PCSrcW` input 1: Writeback redirect request.
- `BranchTargetE` input N: branch target from Execute.
- `BranchTakenE` input 1: Execute redirect request.
- `ReadyD` input 1: decode accepts the head entry this cycle.
- `PCF` output N: current fetch address.
- `ValidD` output 1: head entry valid.
- `VectorD` output 1: head entry has V bit set.
- `InstrD` output N: head instruction when valid and scalar, else 0.
- `InstrD_vector` output N: head instruction when valid and vector, else 0.
- `PCPlus8D` output N: head PC + 8 when valid, else 0.
- `CountF` output $clog2(DEPTH)+1: current queue occupancy.

## Operation
- State:
  - PC register.
  - FIFO storage: DEPTH × {pc, instr}.
  - Read and write pointers, each $clog2(DEPTH) bits, wrapping modulo DEPTH.
  - Count register, 0..DEPTH.
- Redirect:
  - `redir` = `PCSrcW` | `BranchTakenE`.
  - Target = `ResultW` if `PCSrcW`, else `BranchTargetE`. Writeback has priority when both are asserted.
- Push:
  - `push` = !`redir` & (count < DEPTH | `pop`).
  - On push, entry {`PCF`, `instruction`} is written at the write pointer, and PC ← PC + `PC_STEP`.
  - With no push and no redirect, PC holds.
- Pop:
  - `pop` = `ValidD` & `ReadyD`.
  - `ValidD` = (count ≠ 0) & !`redir`.
  - On pop, the read pointer advances.
- Count update: +1 on push only, −1 on pop only, unchanged on both or neither.
- On a redirect edge:
  - Pointers and count clear to 0 and PC ← target.
  - The instruction fetched that cycle is discarded.
  - The head is discarded even if `ReadyD` = 1.
- Full (count = DEPTH):
  - Fetch stalls and PC holds.
  - If pop occurs in the same cycle, push also occurs and count stays at DEPTH.
- Empty (count = 0): `ValidD` = 0 and all data outputs are 0. `ReadyD` is ignored.
- Lane routing: `VectorD` = head instr[VBIT]. Exactly one of `InstrD` / `InstrD_vector` is nonzero-capable when `ValidD` = 1.
- Arithmetic: all PC additions are modulo 2^N and wrap silently.

## Timing
- Reset (`rst` = 0), taking effect immediately and asynchronously:
  - PC = `RESET_PC`, count = 0, pointers = 0.
  - `PCF` = `RESET_PC`, `ValidD` = 0, `VectorD` = 0, `InstrD` = 0, `InstrD_vector` = 0, `PCPlus8D` = 0, `CountF` = 0.
- Reset mid-operation discards all queue contents.
- Fetch-to-decode latency: 1 cycle. An instruction read at edge k is visible at the head after edge k, when the queue was empty.
- Decode outputs are a combinational function of registered state and of `PCSrcW` / `BranchTakenE` (for `ValidD` gating only). There is no path from `instruction` to the D outputs.
- Redirect-to-first-valid latency: 2 edges. The edge with the redirect loads the target; the next edge pushes the target instruction, and `ValidD` rises after it.
- Sustained throughput: one instruction per cycle while `ReadyD` = 1.
- `ReadyD` may be asserted while `ValidD` = 0; it has no effect.

## Test plan
1. Reset release, memory word at address A = 24'h000000 + 4k, `ReadyD` = 0:
   - `PCF` = 0, 4, 8, 12 on successive edges, then holds at 16.
   - `CountF` reaches 4, `ValidD` = 1, `PCPlus8D` = 8.
2. Full queue, then `ReadyD` = 1 continuously:
   - Pops PCs 0, 4, 8, … in order, one per cycle.
   - `CountF` stays at 4 and `PCF` advances by 4 per cycle.
3. Redirect priority: with the queue holding 3 entries, assert `BranchTakenE` = 1 with `BranchTargetE` = 24'h40, and in the same cycle `PCSrcW` = 1 with `ResultW` = 24'h80.
   - `ValidD` = 0 in that cycle and `CountF` = 0 after the edge.
   - `PCF` = 24'h80, and the first popped entry has `PCPlus8D` = 24'h88.
4. Lane routing: head word = 24'h100005 (bit 20 set).
   - `VectorD` = 1, `InstrD_vector` = 24'h100005, `InstrD` = 0.
   - Next word 24'h000005: `InstrD` = 24'h000005, `InstrD_vector` = 0.
5. Asynchronous reset pulse mid-stream, between clock edges:
   - All outputs go to their reset values immediately.
   - After release, fetch restarts at `RESET_PC`.
6. PC wrap:
   - `ResultW` = 24'hFFFFFC redirect: fetched PCs are FFFFFC, then 000000.
   - `PCPlus8D` for the head at FFFFFC = 24'h000004.
